// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle for alu_op_sequencer.
// master: command producer / response consumer; slave: the sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [2:0]   cmd_op;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic [2:0]   rsp_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_op
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the registered ALU: buffers commands in a FIFO,
// issues one enable pulse per command, captures result/flags after ALU_LAT
// edges and returns them over a valid/ready response channel.
// Optional: define SEQ_CHECK_EN to add a reference model and the sticky
// chk_err / chk_err_op outputs.
module alu_op_sequencer #(
    parameter int unsigned N       = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic [2:0]         alu_op,
    output logic               alu_en,
    input  logic [N-1:0]       alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic [15:0]        done_count
`ifdef SEQ_CHECK_EN
    ,
    output logic               chk_err,
    output logic [2:0]         chk_err_op
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } entry_t;

    state_t             state, state_d;
    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic [LAT_W-1:0]   wait_cnt;
    logic               push_c, pop_c, capture_c, ack_c;

    assign push_c = bus.cmd_valid && bus.cmd_ready;
    assign head   = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        if (push_c && !pop_c) begin
            count_next = count + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_next = count - CNT_W'(1);
        end
    end

    // FIFO storage write, no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_d   = state;
        pop_c     = 1'b0;
        capture_c = 1'b0;
        ack_c     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop_c   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture_c = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    ack_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, issue registers, latency counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.cmd_ready  <= 1'b1;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            alu_en         <= 1'b0;
            wait_cnt       <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_op     <= '0;
            done_count     <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                alu_a  <= head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end
            count         <= count_next;
            bus.cmd_ready <= (count_next != CNT_W'(DEPTH));
            alu_en        <= (state_d == ISSUE);

            if (state == ISSUE) begin
                wait_cnt <= LAT_W'(ALU_LAT - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - LAT_W'(1);
            end

            if (capture_c) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_result <= alu_result;
                bus.rsp_carry  <= alu_carry;
                bus.rsp_zero   <= alu_zero;
                bus.rsp_op     <= alu_op;
            end else if (ack_c) begin
                bus.rsp_valid  <= 1'b0;
            end

            if (ack_c) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

`ifdef SEQ_CHECK_EN
    logic [N:0] ref_q;
    logic       mismatch_c;

    // Reference {carry, result} for one opcode.
    function automatic logic [N:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    ref_alu = {1'b0, a} + {1'b0, b};
            3'd1:    ref_alu = {1'b0, a} - {1'b0, b};
            3'd2:    ref_alu = {1'b0, a & b};
            3'd3:    ref_alu = {1'b0, ~a};
            3'd4:    ref_alu = {1'b0, a | b};
            3'd5:    ref_alu = {1'b0, a ^ b};
            3'd6:    ref_alu = {a, 1'b0};
            default: ref_alu = {a[0], 1'b0, a[N-1:1]};
        endcase
    endfunction

    assign mismatch_c = ({alu_carry, alu_result} != ref_q) ||
                        (alu_zero != (ref_q[N-1:0] == '0));

    // Model registered on the issued operands; sticky flag on first mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q      <= '0;
            chk_err    <= 1'b0;
            chk_err_op <= '0;
        end else begin
            if (state == ISSUE) begin
                ref_q <= ref_alu(alu_a, alu_b, alu_op);
            end
            if (capture_c && mismatch_c && !chk_err) begin
                chk_err    <= 1'b1;
                chk_err_op <= alu_op;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered ALU responder and a
// response scoreboard.
module tb_alu_op_sequencer;
    localparam int unsigned N       = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ALU_LAT = 1;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic [2:0] op;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_en, alu_carry, alu_zero;
    logic [15:0] done_count;
    logic        fault_en = 1'b0;
    rsp_t        alu_q = '0;
`ifdef SEQ_CHECK_EN
    logic        chk_err;
    logic [2:0]  chk_err_op;
`endif

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int en_pulses = 0;
    int rv_seen = 0;
    int double_en = 0;
    logic en_prev = 1'b0;
    rsp_t sb[$];

    alu_op_sequencer_if #(.N(N)) bus ();

    alu_op_sequencer #(.N(N), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .done_count(done_count)
`ifdef SEQ_CHECK_EN
        , .chk_err(chk_err), .chk_err_op(chk_err_op)
`endif
    );

    always #5 clk = ~clk;

    function automatic rsp_t alu_f(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic flt);
        logic [8:0] r;
        rsp_t       o;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, ~a};
            3'd4:    r = {1'b0, a | b};
            3'd5:    r = {1'b0, a ^ b};
            3'd6:    r = {a[7], a[6:0], 1'b0};
            default: r = {a[0], 1'b0, a[7:1]};
        endcase
        if (flt && op == 3'b100) r = 9'h001;
        o.result = r[7:0];
        o.carry  = r[8];
        o.zero   = (r[7:0] == 8'h00);
        o.op     = op;
        return o;
    endfunction

    // Registered ALU responder, latency one edge after the enable sample.
    always @(posedge clk) begin
        if (alu_en) alu_q <= alu_f(alu_op, alu_a, alu_b, fault_en);
    end
    assign alu_result = alu_q.result;
    assign alu_carry  = alu_q.carry;
    assign alu_zero   = alu_q.zero;

    // Activity monitor: enable pulses, back-to-back enables, valid cycles.
    always @(negedge clk) begin
        if (alu_en) en_pulses++;
        if (alu_en && en_prev) double_en++;
        en_prev = alu_en;
        if (bus.rsp_valid) rv_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        sb.push_back(alu_f(op, a, b, fault_en));
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        rsp_t e;
        int   i;
        i = 0;
        while (!bus.rsp_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (bus.rsp_valid && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(bus.rsp_result), 32'(e.result));
            check({tag, "_carry"},  32'(bus.rsp_carry),  32'(e.carry));
            check({tag, "_zero"},   32'(bus.rsp_zero),   32'(e.zero));
            check({tag, "_op"},     32'(bus.rsp_op),     32'(e.op));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            @(posedge clk);
            exp_done++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] snap;
        int          pulses0, rv0;

        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_done", 32'(done_count), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);

        // Single add with overflow to zero, latency push + ALU_LAT + 2
        push(3'b000, 8'd250, 8'd6);
        repeat (ALU_LAT + 1) @(negedge clk);
        check("lat_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_on_time", 32'(bus.rsp_valid), 32'd1);
        check("t1_result_const", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_op}),
              32'({8'h00, 1'b1, 1'b1, 3'b000}));
        get_rsp("t1");
        check("t1_done", 32'(done_count), 32'(exp_done));
        check("t1_done_one", 32'(done_count), 32'd1);

        // Stalled response with the FIFO filled behind it
        bus.rsp_ready = 1'b0;
        push(3'b100, 8'hF0, 8'h0F);
        get_rsp("hold");
        snap    = {bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_valid, bus.rsp_op, 2'b00};
        pulses0 = en_pulses;
        push(3'b000, 8'd2, 8'd3);
        push(3'b010, 8'd23, 8'd20);
        push(3'b011, 8'd25, 8'd0);
        push(3'b101, 8'd15, 8'd3);
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("hold_stable", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_valid,
              bus.rsp_op, 2'b00}), 32'(snap));
        check("hold_no_issue", 32'(en_pulses), 32'(pulses0));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        exp_done++;
        @(negedge clk);
        check("ack_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("ack_still_full", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("pop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("q_head_const", 32'(sb[0].result), 32'h05);
        get_rsp("q0");
        get_rsp("q1");
        get_rsp("q2");
        get_rsp("q3");
        check("q_done", 32'(done_count), 32'(exp_done));

        // Simultaneous push and pop at three entries
        bus.rsp_ready = 1'b0;
        push(3'b001, 8'd10, 8'd20);
        get_rsp("pp_hold");
        push(3'b110, 8'h81, 8'h00);
        push(3'b111, 8'h03, 8'h00);
        push(3'b000, 8'h80, 8'h80);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        exp_done++;
        @(negedge clk);
        push(3'b101, 8'hAA, 8'h55);
        check("pp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        push(3'b001, 8'd5, 8'd5);
        check("pp_occupancy", 32'(bus.cmd_ready), 32'd0);
        get_rsp("pp0");
        get_rsp("pp1");
        get_rsp("pp2");
        get_rsp("pp3");
        get_rsp("pp4");
        check("pp_done", 32'(done_count), 32'(exp_done));

        // Reset while waiting on the ALU with two commands queued
        push(3'b000, 8'd1, 8'd1);
        push(3'b010, 8'hFF, 8'h0F);
        push(3'b100, 8'h01, 8'h02);
        #1 rst = 1'b1;
        #1;
        check("mrst_alu_en", 32'(alu_en), 32'd0);
        check("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mrst_done", 32'(done_count), 32'd0);
        check("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        sb.delete();
        exp_done = 0;
        @(negedge clk);
        rst = 1'b0;
        pulses0 = en_pulses;
        rv0     = rv_seen;
        repeat (10) @(negedge clk);
        check("mrst_no_issue", 32'(en_pulses), 32'(pulses0));
        check("mrst_no_rsp", 32'(rv_seen), 32'(rv0));

        // Mixed opcodes with random operands
        for (int i = 0; i < 8; i++) begin
            push(3'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            get_rsp("rnd");
        end
        check("rnd_done", 32'(done_count), 32'(exp_done));

`ifdef SEQ_CHECK_EN
        check("chk_clean", 32'(chk_err), 32'd0);
        fault_en = 1'b1;
        push(3'b100, 8'hF0, 8'h0F);
        get_rsp("flt");
        fault_en = 1'b0;
        check("chk_err_set", 32'(chk_err), 32'd1);
        check("chk_err_op", 32'(chk_err_op), 32'd4);
        push(3'b000, 8'd7, 8'd9);
        get_rsp("flt_after");
        check("chk_err_sticky", 32'(chk_err), 32'd1);
        check("chk_err_op_kept", 32'(chk_err_op), 32'd4);
`endif

        check("single_cycle_en", 32'(double_en), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side initiator for the team's registered 8-bit ALU. Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. Issues each command to the ALU as a one-cycle enable pulse, captures result and flags after the ALU latency, and returns them over a valid/ready response interface. The ALU is the responder; this block replaces the hand-written stimulus sequence used in bring-up.

Parameters:
N, 8, operand/result width
DEPTH, 4, command FIFO entries (power of two, >=2)
ALU_LAT, 1, clock edges from the alu_en sample to a valid alu_result/flags (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (not full)
cmd_a  in  N  operand A
cmd_b  in  N  operand B
cmd_op  in  3  ALU op_code
alu_a  out  N  operand A to ALU
alu_b  out  N  operand B to ALU
alu_op  out  3  op_code to ALU
alu_en  out  1  ALU enable, one-cycle pulse per command
alu_result  in  N  ALU result_out
alu_carry  in  1  ALU flag_carry
alu_zero  in  1  ALU flag_zero
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_result  out  N  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_op  out  3  opcode of this response
done_count  out  16  responses accepted since reset

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; FIFO empty; cmd_ready=1. All of alu_a, alu_b, alu_op, alu_en, rsp_* and done_count =0.
- FIFO: a push occurs when cmd_valid&&cmd_ready. cmd_ready=!full and is registered from the occupancy count.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle are both performed, so occupancy is unchanged.
  - A push while full is impossible because cmd_ready=0.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into the alu_a/alu_b/alu_op registers and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: alu_en=1 for exactly this cycle. Load the wait counter with ALU_LAT-1. Go to WAIT.
  - WAIT: alu_en=0. When the counter is 0, capture alu_result/alu_carry/alu_zero/alu_op into the rsp_* registers, set rsp_valid=1 and go to HOLD. Otherwise decrement the counter.
  - HOLD: rsp_* stay stable while rsp_valid=1 and rsp_ready=0. When rsp_ready=1, clear rsp_valid, increment done_count, and go to IDLE.
- alu_a/alu_b/alu_op hold their values after ISSUE until the next pop.
- Latency: a command pushed into an empty FIFO with the FSM in IDLE produces rsp_valid at push_edge + ALU_LAT + 2. Sustained throughput is one response per ALU_LAT+3 cycles when rsp_ready is held at 1.
- Only one command is in flight at a time. The FIFO keeps accepting commands while the FSM is busy.
- done_count wraps from 0xFFFF to 0.
- Reset mid-operation: the in-flight command and all queued commands are discarded, no response is produced, and alu_en drops immediately.
- Opcode map for the ALU (used by the checker):
  - 000 A+B, carry = bit N
  - 001 A-B, carry = borrow
  - 010 A&B
  - 011 ~A
  - 100 A|B
  - 101 A^B
  - 110 A<<1, carry = A[N-1]
  - 111 A>>1, carry = A[0]
  - zero = (result==0) for all opcodes.

Optional Feature:
SEQ_CHECK_EN
- Defined:
  - Adds a registered reference model of the opcode map, evaluated on the issued operands.
  - At capture, compares result, carry and zero against the model.
  - Adds output port chk_err (1 bit), a sticky flag set on the first mismatch and cleared only by rst.
  - Adds output port chk_err_op (3 bits), the opcode of the first mismatch.
- Undefined: no model logic and no chk_* ports; behaviour is otherwise identical.

Test Plan:
- Push op=000 A=250 B=6 with rsp_ready=1 -> rsp_result=0x00, carry=1, zero=1, rsp_op=000; rsp_valid at push+ALU_LAT+2; done_count=1.
- Push four commands back-to-back: 000 2,3; 010 23,20; 011 25; 101 15,3 -> cmd_ready drops after the 4th push (DEPTH=4) and reasserts on the first pop. Responses in order: 0x05, 0x14, 0xE6, 0x0C.
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable; no further alu_en pulse; the queued command is not issued until the handshake completes.
- Simultaneous push and pop with the FIFO at 3 entries -> occupancy stays 3; cmd_ready stays 1; no entry lost or duplicated.
- Assert rst while in WAIT with 2 commands queued -> alu_en=0, rsp_valid=0, done_count=0, cmd_ready=1 immediately; no stale response after release.
- SEQ_CHECK_EN: drive a fault so alu_result is forced to 0x01 for op=100 A=0xF0 B=0x0F -> chk_err=1, chk_err_op=100; it stays set across later correct ops.
